pwm_fade_ctrl: RTL
==================

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter: PERIOD, default 1000, meaning PWM period in clock cycles (range 2..1023).
REQ-002 Parameter: STEP, default 10, meaning duty increment or decrement per ramp step (range 1..PERIOD).
REQ-003 Port: i_clk, input, 1, single clock; all logic SHALL be on its rising edge.
REQ-004 Port: i_reset, input, 1, reset, synchronous and active-high.
REQ-005 Port: i_cmd_valid, input, 1, fade command present.
REQ-006 Port: o_cmd_ready, output, 1, controller accepts a command this cycle.
REQ-007 Port: i_cmd_target, input, 10, target duty in cycles per period.
REQ-008 Port: i_cmd_rate, input, 8, number of PWM periods per ramp step; 0 means jump.
REQ-009 Port: i_abort, input, 1, stop the ramp and freeze duty at its current value.
REQ-010 Port: o_pwm, output, 1, PWM waveform.
REQ-011 Port: o_duty, output, 10, current duty register.
REQ-012 Port: o_busy, output, 1, high while in RAMP.
REQ-013 Port: o_done, output, 1, one-cycle pulse when duty reaches target.

Function
REQ-014 Period counter SHALL count 0..PERIOD-1 and wrap to 0; the cycle with count==PERIOD-1 SHALL be the "boundary".
REQ-015 o_pwm SHALL be (count < duty); duty 0 SHALL give constant low, and duty PERIOD SHALL give constant high.
REQ-016 Duty SHALL change only on the boundary edge, so every period runs with a single duty value (glitch-free).
REQ-017 FSM states SHALL be IDLE and RAMP; o_cmd_ready SHALL be 1 in IDLE and 0 in RAMP.
REQ-018 A command SHALL be accepted on a cycle with i_cmd_valid && o_cmd_ready; the target SHALL be latched as min(i_cmd_target, PERIOD) and the rate SHALL be latched.
REQ-019 If the latched target equals duty at acceptance, the FSM SHALL stay in IDLE and o_done SHALL pulse on the next cycle.
REQ-020 Otherwise the FSM SHALL go to RAMP and the rate counter SHALL clear.
REQ-021 In RAMP with rate R≥1, a step SHALL apply on every R-th boundary after acceptance.
REQ-022 In RAMP with rate 0, duty SHALL be set to target on the first boundary.
REQ-023 An up-step SHALL be duty = min(duty+STEP, target); a down-step SHALL be duty = max(duty-STEP, target).
REQ-024 Step arithmetic SHALL use width+1 bits, with no wrap or underflow.
REQ-025 On the edge where duty becomes equal to target, the FSM SHALL go to IDLE and o_done SHALL be 1 for exactly the following cycle, during which o_cmd_ready is also 1.
REQ-026 i_abort in RAMP SHALL move the FSM to IDLE on the next edge, keep duty unchanged, and produce no o_done.
REQ-027 i_abort SHALL take priority over a step on the same boundary edge.
REQ-028 i_abort in IDLE SHALL be ignored; a command accepted in the same cycle SHALL proceed.
REQ-029 i_cmd_valid while in RAMP SHALL be ignored (not accepted); the requester holds it until ready.
REQ-030 The period counter SHALL free-run regardless of FSM state.

Reset
REQ-031 On i_reset, state SHALL go to IDLE, and count, duty, rate counter, latched target and latched rate SHALL all be 0.
REQ-032 Immediately after reset: o_pwm=0, o_duty=0, o_busy=0, o_done=0, o_cmd_ready=1.
REQ-033 Reset asserted mid-ramp SHALL abandon the ramp without an o_done pulse; reset SHALL override every other input.

Structure
REQ-034 Shared package pwm_pkg SHALL hold the PERIOD/STEP defaults, the duty width (10), and the FSM state enum.
REQ-035 One sub-module, pwm_period_cnt (0..PERIOD-1 counter with a boundary strobe output), SHALL be used; the FSM, duty and step arithmetic live in the top.
REQ-036 Expected size SHALL be 120-400 RTL lines in total.

Verification (PERIOD=10, STEP=2)
REQ-037 Reset, then idle for 3 cycles -> o_pwm=0, o_duty=0, o_busy=0, o_done=0, o_cmd_ready=1.
REQ-038 From duty 0, command target=6 rate=1 -> duty 2, 4, 6 on the next three boundaries; o_done high for one cycle after the third; then o_pwm high for 6 of every 10 cycles.
REQ-039 From duty 6, command target=1 rate=2 -> duty 4, 2, 1 every second boundary (final step clamped); then a single o_done pulse.
REQ-040 Command target=15 rate=0 -> target clamped to 10; duty=10 at the first boundary; o_pwm constantly high; o_done pulse.
REQ-041 Ramp 0->10 rate=1, with i_abort on the cycle the duty reaches 4, and i_cmd_valid held high during the ramp -> duty frozen at 4, IDLE, no o_done, and the held command accepted only once ready returns.
REQ-042 i_reset asserted mid-ramp at duty 6 -> on the next cycle all outputs at reset values; no o_done.

Source files
------------

// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared constants and FSM encoding for the PWM fade controller.
// Defaults, duty width and ramp-rate width are kept here so top and counter agree.
package pwm_pkg;
  localparam int DUTY_W     = 10;
  localparam int RATE_W     = 8;
  localparam int PERIOD_DEF = 1000;
  localparam int STEP_DEF   = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;
endpackage

// File: rtl/pwm_period_cnt.sv
// Free-running 0..PERIOD-1 counter; o_boundary marks the last cycle of each period.
// Zero latency strobe, no backpressure: counts every cycle out of reset.
module pwm_period_cnt
  import pwm_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic [DUTY_W-1:0] o_count,
  output logic              o_boundary
);

  localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PERIOD - 1);

  logic [DUTY_W-1:0] r_count;
  logic              w_last;

  assign w_last = (r_count == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset)     r_count <= '0;
    else if (w_last) r_count <= '0;
    else             r_count <= r_count + 1'b1;
  end

  assign o_count    = r_count;
  assign o_boundary = w_last;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM generator whose duty ramps toward a commanded target, one step per R periods.
// Commands are accepted only in IDLE (ready/valid); duty changes only at period boundaries.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF,
  parameter int STEP   = STEP_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [DUTY_W-1:0] i_cmd_target,
  input  logic [RATE_W-1:0] i_cmd_rate,
  input  logic              i_abort,
  output logic              o_pwm,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_busy,
  output logic              o_done
);

  localparam int              EW       = DUTY_W + 1;
  localparam logic [EW-1:0]   PERIOD_E = EW'(PERIOD);
  localparam logic [EW-1:0]   STEP_E   = EW'(STEP);

  state_t            r_state, w_state_nxt;
  logic [DUTY_W-1:0] r_duty, r_target;
  logic [RATE_W-1:0] r_rate, r_rate_cnt;
  logic              r_done;

  logic [DUTY_W-1:0] w_count;
  logic              w_boundary;
  logic              w_accept, w_match, w_ramp_bnd, w_step_due, w_reach;
  logic [DUTY_W-1:0] w_target_clamp;
  logic [EW-1:0]     w_cmd_target_e, w_duty_e, w_tgt_e, w_up_e, w_dn_e, w_step_e;

  pwm_period_cnt #(.PERIOD(PERIOD)) u_period_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .o_count    (w_count),
    .o_boundary (w_boundary)
  );

  assign w_cmd_target_e = {1'b0, i_cmd_target};
  assign w_target_clamp = (w_cmd_target_e > PERIOD_E) ? PERIOD_E[DUTY_W-1:0] : i_cmd_target;
  assign w_accept       = i_cmd_valid && (r_state == ST_IDLE);
  assign w_match        = (w_target_clamp == r_duty);

  // Abort wins over a step landing on the same boundary.
  assign w_ramp_bnd = (r_state == ST_RAMP) && !i_abort && w_boundary;
  assign w_step_due = w_ramp_bnd && ((r_rate == '0) || (r_rate_cnt == (r_rate - 1'b1)));

  // One extra bit of headroom keeps up-steps from wrapping and down-steps from underflowing.
  assign w_duty_e = {1'b0, r_duty};
  assign w_tgt_e  = {1'b0, r_target};
  assign w_up_e   = w_duty_e + STEP_E;
  assign w_dn_e   = w_duty_e - STEP_E;

  always_comb begin
    w_step_e = w_tgt_e;
    if (r_rate != '0) begin
      if (w_tgt_e > w_duty_e) w_step_e = (w_up_e >= w_tgt_e) ? w_tgt_e : w_up_e;
      else                    w_step_e = (w_duty_e >= (w_tgt_e + STEP_E)) ? w_dn_e : w_tgt_e;
    end
  end

  assign w_reach = w_step_due && (w_step_e == w_tgt_e);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !w_match)  w_state_nxt = ST_RAMP;
      ST_RAMP: if (i_abort || w_reach)     w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = (r_state == ST_IDLE);
    o_busy      = (r_state == ST_RAMP);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_duty     <= '0;
      r_target   <= '0;
      r_rate     <= '0;
      r_rate_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (w_accept && w_match) || w_reach;
      if (w_accept) begin
        r_target   <= w_target_clamp;
        r_rate     <= i_cmd_rate;
        r_rate_cnt <= '0;
      end
      if (w_step_due) begin
        r_duty     <= w_step_e[DUTY_W-1:0];
        r_rate_cnt <= '0;
      end else if (w_ramp_bnd) begin
        r_rate_cnt <= r_rate_cnt + 1'b1;
      end
    end
  end

  assign o_pwm  = (w_count < r_duty);
  assign o_duty = r_duty;
  assign o_done = r_done;

endmodule
